// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - gshare predictor default sizes and counter init helper
package bp_pkg;

   localparam int DEF_IDX_W  = 6;
   localparam int DEF_HIST_W = 6;
   localparam int DEF_CTR_W  = 2;
   localparam int DEF_STAT_W = 16;

   // Weakly-not-taken: just below the taken threshold; a 1-bit counter starts at 0.
   function automatic int unsigned wnt_init(input int unsigned ctr_w);
      if (ctr_w <= 1) return 0;
      return (1 << (ctr_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/spec_ghr.sv
// rtl/spec_ghr.sv - speculative global history register; repair beats fetch shift
module spec_ghr #(
   parameter int HIST_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              shift_en,
   input  logic              shift_bit,
   input  logic              repair_en,
   input  logic [HIST_W-1:0] repair_ghr,
   input  logic              repair_bit,
   output logic [HIST_W-1:0] ghr
);

   logic [HIST_W-1:0] ghr_q;
   logic [HIST_W-1:0] ghr_d;

   // Shifting through a HIST_W+1 wide temporary keeps HIST_W=1 legal (result is just the new bit).
   function automatic logic [HIST_W-1:0] push_bit(input logic [HIST_W-1:0] h, input logic b);
      logic [HIST_W:0] t;
      t = {h, b};
      return t[HIST_W-1:0];
   endfunction

   always_comb begin
      ghr_d = ghr_q;
      if (repair_en) begin
         ghr_d = push_bit(repair_ghr, repair_bit);
      end else if (shift_en) begin
         ghr_d = push_bit(ghr_q, shift_bit);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ghr_q <= '0;
      end else begin
         ghr_q <= ghr_d;
      end
   end

   assign ghr = ghr_q;

endmodule

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare direction predictor: PHT, lookup/update ports, statistics
module gshare_predictor
   import bp_pkg::*;
#(
   parameter int IDX_W  = DEF_IDX_W,
   parameter int HIST_W = DEF_HIST_W,
   parameter int CTR_W  = DEF_CTR_W,
   parameter int STAT_W = DEF_STAT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IDX_W-1:0]  pc_f,
   input  logic              is_branch_f,
   input  logic              shift_f,
   output logic              pred_f,
   output logic [HIST_W-1:0] ghr_f,
   input  logic              upd_valid,
   input  logic [IDX_W-1:0]  upd_pc,
   input  logic [HIST_W-1:0] upd_ghr,
   input  logic              upd_taken,
   input  logic              upd_mispredict,
   input  logic              stat_clear,
   output logic [STAT_W-1:0] stat_branches,
   output logic [STAT_W-1:0] stat_mispred
);

   localparam int ENTRIES = 1 << IDX_W;
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(wnt_init(CTR_W));
   localparam logic [CTR_W-1:0] CTR_MAX  = '1;

   generate
      if (HIST_W > IDX_W || CTR_W < 1) begin : g_bad_params
         $error("gshare_predictor: need HIST_W <= IDX_W and CTR_W >= 1");
      end
   endgenerate

   logic [CTR_W-1:0]  pht_q [ENTRIES];
   logic [CTR_W-1:0]  pht_d [ENTRIES];
   logic [STAT_W-1:0] br_cnt_q, br_cnt_d;
   logic [STAT_W-1:0] mp_cnt_q, mp_cnt_d;
   logic [IDX_W-1:0]  lk_idx;
   logic [IDX_W-1:0]  up_idx;
   logic [CTR_W-1:0]  up_ctr;

   assign lk_idx = pc_f ^ IDX_W'(ghr_f);
   assign up_idx = upd_pc ^ IDX_W'(upd_ghr);
   assign up_ctr = pht_q[up_idx];

   // Lookup reads the registered table, so a same-cycle update is not visible until the edge.
   assign pred_f = is_branch_f & ~reset & pht_q[lk_idx][CTR_W-1];

   spec_ghr #(.HIST_W(HIST_W)) u_spec_ghr (
      .clk        (clk),
      .reset      (reset),
      .shift_en   (shift_f & is_branch_f),
      .shift_bit  (pred_f),
      .repair_en  (upd_valid & upd_mispredict),
      .repair_ghr (upd_ghr),
      .repair_bit (upd_taken),
      .ghr        (ghr_f)
   );

   always_comb begin
      pht_d = pht_q;
      if (upd_valid) begin
         if (upd_taken && up_ctr != CTR_MAX) begin
            pht_d[up_idx] = up_ctr + 1'b1;
         end else if (!upd_taken && up_ctr != '0) begin
            pht_d[up_idx] = up_ctr - 1'b1;
         end
      end
   end

   always_comb begin
      br_cnt_d = br_cnt_q;
      mp_cnt_d = mp_cnt_q;
      if (stat_clear) begin
         br_cnt_d = '0;
         mp_cnt_d = '0;
      end else if (upd_valid) begin
         if (br_cnt_q != '1) br_cnt_d = br_cnt_q + 1'b1;
         if (upd_mispredict && mp_cnt_q != '1) mp_cnt_d = mp_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pht_q    <= '{default: CTR_INIT};
         br_cnt_q <= '0;
         mp_cnt_q <= '0;
      end else begin
         pht_q    <= pht_d;
         br_cnt_q <= br_cnt_d;
         mp_cnt_q <= mp_cnt_d;
      end
   end

   assign stat_branches = br_cnt_q;
   assign stat_mispred  = mp_cnt_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - scoreboard bench for gshare_predictor with directed vectors
module tb_gshare_predictor;

   localparam int IDX_W  = 6;
   localparam int HIST_W = 6;
   localparam int CTR_W  = 2;
   localparam int STAT_W = 4;

   logic              clk;
   logic              reset;
   logic [IDX_W-1:0]  pc_f;
   logic              is_branch_f;
   logic              shift_f;
   logic              pred_f;
   logic [HIST_W-1:0] ghr_f;
   logic              upd_valid;
   logic [IDX_W-1:0]  upd_pc;
   logic [HIST_W-1:0] upd_ghr;
   logic              upd_taken;
   logic              upd_mispredict;
   logic              stat_clear;
   logic [STAT_W-1:0] stat_branches;
   logic [STAT_W-1:0] stat_mispred;

   gshare_predictor #(
      .IDX_W(IDX_W), .HIST_W(HIST_W), .CTR_W(CTR_W), .STAT_W(STAT_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .pc_f           (pc_f),
      .is_branch_f    (is_branch_f),
      .shift_f        (shift_f),
      .pred_f         (pred_f),
      .ghr_f          (ghr_f),
      .upd_valid      (upd_valid),
      .upd_pc         (upd_pc),
      .upd_ghr        (upd_ghr),
      .upd_taken      (upd_taken),
      .upd_mispredict (upd_mispredict),
      .stat_clear     (stat_clear),
      .stat_branches  (stat_branches),
      .stat_mispred   (stat_mispred)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum int {K_PRED, K_GHR, K_BR, K_MP} kind_e;
   typedef struct {
      kind_e       kind;
      logic [15:0] exp;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   n_total;
   int   n_pass;

   task automatic expect_val(input kind_e k, input logic [15:0] v, input string nm);
      exp_t e;
      e.kind = k;
      e.exp  = v;
      e.name = nm;
      sb_q.push_back(e);
   endtask

   // Monitor: outputs are settled mid-cycle, so every queued expectation is judged on the falling edge.
   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         exp_t        e;
         logic [15:0] got;
         e = sb_q.pop_front();
         case (e.kind)
            K_PRED:  got = 16'(pred_f);
            K_GHR:   got = 16'(ghr_f);
            K_BR:    got = 16'(stat_branches);
            default: got = 16'(stat_mispred);
         endcase
         n_total++;
         if (got === e.exp) n_pass++;
         else $display("FAIL %s: got %0h, expected %0h", e.name, got, e.exp);
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
      pc_f = '0; is_branch_f = 1'b0; shift_f = 1'b0;
      upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
      stat_clear = 1'b0;
   endtask

   task automatic fetch(input logic [IDX_W-1:0] pc, input logic br, input logic sh);
      pc_f = pc; is_branch_f = br; shift_f = sh;
   endtask

   task automatic upd(input logic [IDX_W-1:0] pc, input logic [HIST_W-1:0] g,
                      input logic tk, input logic mp);
      upd_valid = 1'b1; upd_pc = pc; upd_ghr = g; upd_taken = tk; upd_mispredict = mp;
   endtask

   task automatic expect_stats(input logic [15:0] br, input logic [15:0] mp, input string nm);
      expect_val(K_BR, br, {nm, "_branches"});
      expect_val(K_MP, mp, {nm, "_mispred"});
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      reset = 1'b1;
      pc_f = '0; is_branch_f = 1'b0; shift_f = 1'b0;
      upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
      stat_clear = 1'b0;

      next_cycle();
      next_cycle();
      fetch(6'h05, 1'b1, 1'b1);
      upd(6'h05, 6'h00, 1'b1, 1'b1);
      expect_val(K_PRED, 16'd0, "pred_in_reset");
      expect_val(K_GHR, 16'd0, "ghr_in_reset");
      expect_stats(16'd0, 16'd0, "stats_in_reset");
      next_cycle();
      reset = 1'b0;

      for (int i = 0; i < 64; i++) begin
         next_cycle();
         fetch(6'(i), 1'b1, 1'b0);
         expect_val(K_PRED, 16'd0, "sweep_pred");
         if (i == 63) expect_val(K_GHR, 16'd0, "sweep_ghr");
      end

      // Entry 5: 1 -> 2 -> 3 -> 3, then back down 3 -> 2 -> 1.
      next_cycle(); fetch(6'h05, 1'b1, 1'b0); upd(6'h05, 6'h00, 1'b1, 1'b0);
      expect_val(K_PRED, 16'd0, "train_ctr1");
      next_cycle(); fetch(6'h05, 1'b1, 1'b0); upd(6'h05, 6'h00, 1'b1, 1'b0);
      expect_val(K_PRED, 16'd1, "train_ctr2");
      next_cycle(); fetch(6'h05, 1'b1, 1'b0); upd(6'h05, 6'h00, 1'b1, 1'b0);
      expect_val(K_PRED, 16'd1, "train_ctr3");
      next_cycle(); fetch(6'h05, 1'b1, 1'b0); upd(6'h05, 6'h00, 1'b0, 1'b0);
      expect_val(K_PRED, 16'd1, "train_sat3");
      next_cycle(); fetch(6'h05, 1'b1, 1'b0); upd(6'h05, 6'h00, 1'b0, 1'b0);
      expect_val(K_PRED, 16'd1, "train_dec2");
      next_cycle(); fetch(6'h05, 1'b1, 1'b0);
      expect_val(K_PRED, 16'd0, "train_dec1");
      expect_stats(16'd5, 16'd0, "stats_after_train");

      next_cycle(); upd(6'h10, 6'h00, 1'b1, 1'b0);
      next_cycle(); fetch(6'h10, 1'b1, 1'b1);
      expect_val(K_PRED, 16'd1, "shift1_pred");
      expect_val(K_GHR, 16'h00, "shift1_ghr");
      next_cycle(); fetch(6'h20, 1'b1, 1'b1);
      expect_val(K_PRED, 16'd0, "shift2_pred");
      expect_val(K_GHR, 16'h01, "shift2_ghr");
      next_cycle(); fetch(6'h10, 1'b0, 1'b1);
      expect_val(K_GHR, 16'h02, "two_shifts_ghr");
      expect_val(K_PRED, 16'd0, "not_branch_pred");
      next_cycle();
      upd_mispredict = 1'b1; upd_ghr = 6'h3F; upd_taken = 1'b1;
      expect_val(K_GHR, 16'h02, "shift_no_branch_ignored");
      next_cycle(); upd(6'h3F, 6'h00, 1'b0, 1'b1);
      expect_val(K_GHR, 16'h02, "mispred_no_valid_ignored");
      next_cycle(); fetch(6'h10, 1'b1, 1'b1);
      expect_val(K_GHR, 16'h00, "repair_to_zero");
      expect_val(K_PRED, 16'd1, "reshift_pred");
      next_cycle(); fetch(6'h20, 1'b1, 1'b1); upd(6'h00, 6'h07, 1'b0, 1'b1);
      expect_val(K_GHR, 16'h01, "reshift_ghr");
      next_cycle(); fetch(6'h1E, 1'b1, 1'b0);
      expect_val(K_GHR, 16'h0E, "repair_wins");
      expect_val(K_PRED, 16'd1, "xor_idx_taken");
      next_cycle(); fetch(6'h10, 1'b1, 1'b0);
      expect_val(K_PRED, 16'd0, "xor_idx_not_taken");

      // Index 0x2A reached through ghr 0x0E: pc 0x24.
      next_cycle(); fetch(6'h24, 1'b1, 1'b0); upd(6'h2A, 6'h00, 1'b1, 1'b0);
      expect_val(K_PRED, 16'd0, "same_cycle_no_bypass");
      next_cycle(); fetch(6'h24, 1'b1, 1'b0);
      expect_val(K_PRED, 16'd1, "after_update_edge");
      expect_stats(16'd9, 16'd2, "stats_mid");

      next_cycle(); stat_clear = 1'b1;
      next_cycle();
      expect_stats(16'd0, 16'd0, "stats_cleared");
      for (int i = 0; i < 20; i++) begin
         next_cycle(); upd(6'h30, 6'h00, 1'b1, 1'b1);
      end
      next_cycle();
      expect_stats(16'd15, 16'd15, "stats_saturated");
      next_cycle(); stat_clear = 1'b1; upd(6'h30, 6'h00, 1'b1, 1'b1);
      next_cycle(); upd(6'h30, 6'h00, 1'b1, 1'b0);
      expect_stats(16'd0, 16'd0, "clear_beats_incr");
      next_cycle();
      expect_stats(16'd1, 16'd0, "stats_one_update");

      next_cycle(); fetch(6'h31, 1'b1, 1'b0);
      expect_val(K_PRED, 16'd1, "pre_reset_pred");
      expect_val(K_GHR, 16'h01, "pre_reset_ghr");
      next_cycle(); fetch(6'h31, 1'b1, 1'b1); upd(6'h30, 6'h00, 1'b1, 1'b1);
      #1;
      reset = 1'b1;
      expect_val(K_PRED, 16'd0, "async_reset_pred");
      expect_val(K_GHR, 16'h00, "async_reset_ghr");
      expect_stats(16'd0, 16'd0, "async_reset_stats");
      next_cycle(); fetch(6'h30, 1'b1, 1'b1); upd(6'h30, 6'h00, 1'b1, 1'b1);
      expect_val(K_PRED, 16'd0, "held_reset_pred");
      next_cycle();
      reset = 1'b0;
      fetch(6'h30, 1'b1, 1'b0);
      expect_val(K_PRED, 16'd0, "reinit_0x30");
      expect_val(K_GHR, 16'h00, "reinit_ghr");
      expect_stats(16'd0, 16'd0, "reinit_stats");
      next_cycle(); fetch(6'h10, 1'b1, 1'b0);
      expect_val(K_PRED, 16'd0, "reinit_0x10");
      next_cycle(); fetch(6'h2A, 1'b1, 1'b0);
      expect_val(K_PRED, 16'd0, "reinit_0x2A");

      next_cycle();
      next_cycle();
      n_total++;
      if (sb_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 Parameters: IDX_W, 6, PHT index width; the table holds 2**IDX_W entries.
REQ-002 Parameters: HIST_W, 6, global history length; HIST_W SHALL be at most IDX_W.
REQ-003 Parameters: CTR_W, 2, saturating counter width; CTR_W SHALL be at least 1.
REQ-004 Parameters: STAT_W, 16, width of the statistics counters.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 pc_f  in  IDX_W  low PC bits of the instruction in fetch.
REQ-008 is_branch_f  in  1  fetch instruction is a conditional branch.
REQ-009 shift_f  in  1  fetch branch advances this cycle; shift speculative history.
REQ-010 pred_f  out  1  predicted direction, combinational.
REQ-011 ghr_f  out  HIST_W  speculative history used for this lookup; carried down the pipe.
REQ-012 upd_valid  in  1  resolved branch update this cycle.
REQ-013 upd_pc  in  IDX_W  low PC bits of the resolved branch.
REQ-014 upd_ghr  in  HIST_W  history that was captured with that branch at fetch.
REQ-015 upd_taken  in  1  actual outcome.
REQ-016 upd_mispredict  in  1  resolved outcome differed from prediction; qualified by upd_valid.
REQ-017 stat_clear  in  1  synchronous clear of the statistics counters.
REQ-018 stat_branches  out  STAT_W  count of resolved updates.
REQ-019 stat_mispred  out  STAT_W  count of resolved mispredicts.

Function
REQ-020 Lookup index SHALL be pc_f XOR ghr_f zero-extended to IDX_W; pred_f SHALL be the MSB of the indexed counter when is_branch_f=1, otherwise 0.
REQ-021 Update index SHALL be upd_pc XOR upd_ghr zero-extended. When upd_valid=1 the counter SHALL increment if upd_taken=1 and decrement otherwise, saturating at 2**CTR_W-1 and 0.
REQ-022 Table writes SHALL take effect at the clock edge. A same-cycle lookup of the entry being updated SHALL return the pre-update value, with no bypass.
REQ-023 shift_f=1 with is_branch_f=1 SHALL load ghr_spec with {ghr_spec[HIST_W-2:0], pred_f}. shift_f with is_branch_f=0 SHALL be ignored.
REQ-024 upd_valid=1 with upd_mispredict=1 SHALL repair ghr_spec to {upd_ghr[HIST_W-2:0], upd_taken}. Repair SHALL take priority over a same-cycle shift_f.
REQ-025 upd_mispredict with upd_valid=0 SHALL have no effect.
REQ-026 HIST_W=1 SHALL degenerate to ghr_spec being the last outcome bit, with the same priority rules.
REQ-027 stat_branches SHALL increment on every upd_valid=1.
REQ-028 stat_mispred SHALL increment on every upd_valid=1 with upd_mispredict=1.
REQ-029 Both statistics counters SHALL saturate at all-ones with no wrap. stat_clear SHALL zero both and take priority over a same-cycle increment.
REQ-030 Update and lookup SHALL be independent: one update and one lookup are accepted per cycle, with no stall or handshake.

Reset
REQ-031 Reset SHALL set every PHT entry (all 2**IDX_W) to weakly-not-taken, 2**(CTR_W-1)-1; for CTR_W=1 this value is 0.
REQ-032 Reset SHALL set ghr_spec, and therefore ghr_f, to 0, and both statistics counters to 0.
REQ-033 Reset asserted mid-operation SHALL override any update, shift or repair in that cycle. pred_f SHALL be 0 for every pc while reset is held.

Structure
REQ-034 Package bp_pkg SHALL hold the default IDX_W/HIST_W/CTR_W/STAT_W constants and the weak-not-taken init-value function.
REQ-035 One sub-module, spec_ghr, SHALL hold the speculative history register with its shift/repair priority. The PHT and statistics SHALL stay in gshare_predictor.
REQ-036 An elaboration-time check SHALL reject HIST_W>IDX_W or CTR_W<1.

Verification
REQ-037 Scenario: reset, then sweep pc_f 0..63 with is_branch_f=1 -> pred_f=0 for all 64 entries, ghr_f=0.
REQ-038 Scenario: pc=0x05, ghr=0, three taken updates -> entry goes 1->2->3->3; pred_f for pc_f=0x05, ghr_f=0 becomes 1 after the first update edge.
REQ-039 Scenario: two fetch shifts with pred_f=1, then 0 -> ghr_f=000010. A same-cycle mispredict with upd_ghr=000111, upd_taken=0 instead gives ghr_f=001110, with repair winning.
REQ-040 Scenario: update and lookup of index 0x2A in the same cycle, counter at 1, taken -> pred_f=0 that cycle, 1 the next.
REQ-041 Scenario: STAT_W=4, 20 mispredict updates -> both counters stop at 15; stat_clear together with an update -> both 0.
REQ-042 Scenario: assert reset mid-stream after training -> all entries reinitialised, ghr_f=0, stats 0 immediately, independent of clk.
